// File: rtl/dmem_port_arbiter_if.sv
// Requester-side and memory-side signal bundle for dmem_port_arbiter.
// The arbiter connects through the slave modport; requesters and memory use master.
interface dmem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic          done0, done1;
  logic [DW-1:0] rdata0, rdata1;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, m_rdata,
    output gnt0, gnt1, done0, done1, rdata0, rdata1, m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, m_rdata,
    input  gnt0, gnt1, done0, done1, rdata0, rdata1, m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter and sequencer for the single-port data memory / I/O window.
// Build option DMEM_ARB_CPU_PRIORITY_EN: fixed port-0 priority with a port-1 starvation guard.
module dmem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
`ifdef DMEM_ARB_CPU_PRIORITY_EN
  , parameter int STARVE_LIMIT = 8
`endif
) (
  input  logic               dmem_clk,
  input  logic               reset,
  dmem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state, state_nx;
  logic          grant, win;
  logic          gnt0, gnt1;
  logic          owner, own_we;
  logic          done0_q, done1_q;
  logic          m_en_q, m_we_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_wdata_q;
  logic [DW-1:0] rdata0_q, rdata1_q;

`ifdef DMEM_ARB_CPU_PRIORITY_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  logic [7:0] starve_cnt;

  // Port 0 wins unless port 1 has been passed over LIMIT times in a row.
  always_comb win = bus.req1 & (~bus.req0 | (starve_cnt >= LIMIT));

  always_ff @(posedge dmem_clk) begin
    if (reset || !bus.req1 || gnt1)
      starve_cnt <= '0;
    else if (state == IDLE && starve_cnt != 8'hFF)
      starve_cnt <= starve_cnt + 8'd1;
  end
`else
  logic last;

  // On a tie the port that did not win last time goes next.
  always_comb win = (bus.req0 & bus.req1) ? ~last : bus.req1;

  always_ff @(posedge dmem_clk) begin
    if (reset)
      last <= 1'b1;
    else if (grant)
      last <= win;
  end
`endif

  always_ff @(posedge dmem_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    // NOTE: defaults first so no branch leaves an output unassigned and infers a latch.
    state_nx = state;
    grant    = 1'b0;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          grant    = 1'b1;
          gnt0     = ~win;
          gnt1     = win;
          state_nx = ISSUE;
        end
      end
      ISSUE:   state_nx = own_we ? IDLE : WAIT;
      WAIT:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge dmem_clk) begin
    if (reset) begin
      owner     <= 1'b0;
      own_we    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      m_en_q  <= 1'b0;
      m_we_q  <= 1'b0;
      if (grant) begin
        owner     <= win;
        own_we    <= win ? bus.we1 : bus.we0;
        m_en_q    <= 1'b1;
        m_we_q    <= win ? bus.we1 : bus.we0;
        m_addr_q  <= win ? bus.addr1 : bus.addr0;
        m_wdata_q <= win ? bus.wdata1 : bus.wdata0;
      end
      if (state == ISSUE && own_we) begin
        done0_q <= ~owner;
        done1_q <= owner;
      end
      // Read data arrives the cycle after the strobe; only the owner's rdata moves.
      if (state == WAIT) begin
        done0_q <= ~owner;
        done1_q <= owner;
        if (owner)
          rdata1_q <= bus.m_rdata;
        else
          rdata0_q <= bus.m_rdata;
      end
    end
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.done0   = done0_q;
  assign bus.done1   = done1_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;
  assign bus.m_en    = m_en_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: transaction-schedule model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_dmem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef DMEM_ARB_CPU_PRIORITY_EN
  localparam int LIMIT = 4;
`endif

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  logic dmem_clk = 1'b0;
  logic reset    = 1'b1;
  always #5 dmem_clk = ~dmem_clk;

  dmem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef DMEM_ARB_CPU_PRIORITY_EN
  dmem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
`else
  dmem_port_arbiter #(.AW(AW), .DW(DW)) dut (
`endif
    .dmem_clk (dmem_clk),
    .reset    (reset),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge dmem_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  // Memory contents seen by reads; one fixed word, everything else derived from the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [15:0] lo;
    lo = a[15:0];
    return (a == 32'h10) ? 32'hDEADBEEF : {lo, 16'h5A5A};
  endfunction

  always @(posedge dmem_clk)
    if (bus.m_en && !bus.m_we) bus.m_rdata <= mem_word(bus.m_addr);

  // Reference model: each grant books its strobe, done and next-free cycle.
  logic        e_last   = 1'b1;
  int          free_at  = 0;
  int          iss_c    = -1;
  int          done_c   = -1;
  logic        p_own    = 1'b0;
  logic        p_we     = 1'b0;
  logic [31:0] p_rd     = '0;
  logic [31:0] e_maddr  = '0;
  logic [31:0] e_mwdata = '0;
  logic [31:0] e_rd0    = '0;
  logic [31:0] e_rd1    = '0;
  int          starve   = 0;

  always @(negedge dmem_clk) begin : compare
    logic r0, r1, idle, w, e_g0, e_g1, e_en;
    r0 = bus.req0;
    r1 = bus.req1;
    if (cyc == done_c && !p_we) begin
      if (p_own) e_rd1 = p_rd;
      else       e_rd0 = p_rd;
    end
    e_en = (cyc == iss_c);
    idle = (cyc >= free_at);
    w    = 1'b0;
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (idle && (r0 || r1)) begin
`ifdef DMEM_ARB_CPU_PRIORITY_EN
      w = r1 && (!r0 || starve >= LIMIT);
`else
      w = (r0 && r1) ? !e_last : r1;
`endif
      e_g0 = !w;
      e_g1 = w;
    end

    check("gnt0",    bus.gnt0,    e_g0);
    check("gnt1",    bus.gnt1,    e_g1);
    check("m_en",    bus.m_en,    e_en);
    check("done0",   bus.done0,   cyc == done_c && !p_own);
    check("done1",   bus.done1,   cyc == done_c && p_own);
    check("rdata0",  bus.rdata0,  e_rd0);
    check("rdata1",  bus.rdata1,  e_rd1);
    check("m_addr",  bus.m_addr,  e_maddr);
    check("m_wdata", bus.m_wdata, e_mwdata);
    if (e_en) check("m_we", bus.m_we, p_we);

    if (!r1 || e_g1)  starve = 0;
    else if (idle)    starve = starve + 1;

    if (e_g0 || e_g1) begin
      p_own    = w;
      p_we     = w ? bus.we1 : bus.we0;
      e_maddr  = w ? bus.addr1 : bus.addr0;
      e_mwdata = w ? bus.wdata1 : bus.wdata0;
      p_rd     = mem_word(e_maddr);
      iss_c    = cyc + 1;
      done_c   = cyc + (p_we ? 2 : 3);
      free_at  = done_c;
      e_last   = w;
    end

    if (reset) begin
      iss_c    = -1;
      done_c   = -1;
      free_at  = cyc + 1;
      e_last   = 1'b1;
      starve   = 0;
      e_maddr  = '0;
      e_mwdata = '0;
      e_rd0    = '0;
      e_rd1    = '0;
    end
  end

  // Requesters: each port works through its own op queue, dropping an op once granted.
  op_t q0[$];
  op_t q1[$];
  logic        s_gnt0, s_gnt1, s_done0, s_done1, s_m_en, s_m_we;
  logic [31:0] s_m_addr, s_m_wdata, s_rdata0, s_rdata1;
  int          s_cyc;

  task automatic apply();
    if (q0.size() > 0) begin
      bus.req0 = 1'b1; bus.we0 = q0[0].we; bus.addr0 = q0[0].addr; bus.wdata0 = q0[0].wdata;
    end else bus.req0 = 1'b0;
    if (q1.size() > 0) begin
      bus.req1 = 1'b1; bus.we1 = q1[0].we; bus.addr1 = q1[0].addr; bus.wdata1 = q1[0].wdata;
    end else bus.req1 = 1'b0;
  endtask

  task automatic tick();
    @(negedge dmem_clk);
    s_gnt0 = bus.gnt0;     s_gnt1 = bus.gnt1;
    s_done0 = bus.done0;   s_done1 = bus.done1;
    s_m_en = bus.m_en;     s_m_we = bus.m_we;
    s_m_addr = bus.m_addr; s_m_wdata = bus.m_wdata;
    s_rdata0 = bus.rdata0; s_rdata1 = bus.rdata1;
    s_cyc = cyc;
    @(posedge dmem_clk);
    #1;
    if (s_gnt0 && q0.size() > 0) void'(q0.pop_front());
    if (s_gnt1 && q1.size() > 0) void'(q1.pop_front());
    apply();
  endtask

  task automatic wait_gnt(input int port, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (port == 0 ? s_gnt0 : s_gnt1) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL gnt%0d_timeout: got no grant, want grant within 20 cycles", port);
    end
  endtask

  int gp[$];
  int gc[$];
  int g1_seen;
  int lg_port;
  int lg_cyc;
  bit ok;
`ifdef DMEM_ARB_CPU_PRIORITY_EN
  int exp_order[12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
`endif

  initial begin
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_m_en",   s_m_en,   1'b0);
    check("reset_done0",  s_done0,  1'b0);
    check("reset_rdata0", s_rdata0, 32'h0);
    check("reset_m_addr", s_m_addr, 32'h0);

    // Port 0 read of 0x10
    q0.push_back('{1'b0, 32'h10, 32'h0});
    apply();
    wait_gnt(0, ok);
    if (ok) begin
      tick();
      check("rd_m_en",   s_m_en,   1'b1);
      check("rd_m_addr", s_m_addr, 32'h10);
      tick();
      tick();
      check("rd_done0",  s_done0,  1'b1);
      check("rd_rdata0", s_rdata0, 32'hDEADBEEF);
    end
    repeat (2) tick();

    // Port 1 write into the I/O window
    q1.push_back('{1'b1, 32'hFFFF_FF00, 32'h2A});
    apply();
    wait_gnt(1, ok);
    if (ok) begin
      tick();
      check("io_m_en",    s_m_en,    1'b1);
      check("io_m_we",    s_m_we,    1'b1);
      check("io_m_addr",  s_m_addr,  32'hFFFF_FF00);
      check("io_m_wdata", s_m_wdata, 32'h2A);
      tick();
      check("io_m_en_off", s_m_en,  1'b0);
      check("io_done1",    s_done1, 1'b1);
    end
    repeat (2) tick();

    // Port 1 raises and withdraws while port 0's read is in flight
    q0.push_back('{1'b0, 32'h20, 32'h0});
    apply();
    wait_gnt(0, ok);
    q1.push_back('{1'b0, 32'h30, 32'h0});
    apply();
    tick();
    q1.delete();
    apply();
    g1_seen = 0;
    repeat (6) begin
      tick();
      if (s_gnt1) g1_seen++;
    end
    check("withdraw_gnt1", g1_seen, 0);
    check("withdraw_idle", s_m_en,  1'b0);

    // Reset during the WAIT cycle of a port 1 read
    q1.push_back('{1'b0, 32'h40, 32'h0});
    apply();
    wait_gnt(1, ok);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("abort_m_en",  s_m_en,  1'b0);
    check("abort_done1", s_done1, 1'b0);

`ifdef DMEM_ARB_CPU_PRIORITY_EN
    // Port 0 streams writes while port 1 waits with two reads
    for (int i = 0; i < 10; i++) q0.push_back('{1'b1, 32'h300 + 32'(4 * i), 32'h55});
    q1.push_back('{1'b0, 32'h400, 32'h0});
    q1.push_back('{1'b0, 32'h404, 32'h0});
    apply();
    for (int i = 0; i < 80 && gp.size() < 12; i++) begin
      tick();
      if (s_gnt0) begin gp.push_back(0); gc.push_back(s_cyc); end
      if (s_gnt1) begin gp.push_back(1); gc.push_back(s_cyc); end
    end
    check("starve_grants", gp.size(), 12);
    for (int i = 0; i < gp.size() && i < 12; i++)
      check($sformatf("starve_order%0d", i), gp[i], exp_order[i]);
`else
    // Tie on continuous writes: alternate, port 0 first after reset
    for (int i = 0; i < 3; i++) begin
      q0.push_back('{1'b1, 32'h100 + 32'(4 * i), 32'h11});
      q1.push_back('{1'b1, 32'h200 + 32'(4 * i), 32'h22});
    end
    apply();
    lg_port = -1;
    lg_cyc  = -10;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (lg_port >= 0 && s_cyc == lg_cyc + 1)
        check("rr_m_wdata", s_m_wdata, (lg_port == 1) ? 32'h22 : 32'h11);
      if (lg_port >= 0 && s_cyc == lg_cyc + 2)
        check("rr_done", (lg_port == 1) ? s_done1 : s_done0, 1'b1);
      if (s_gnt0 || s_gnt1) begin
        lg_port = s_gnt1 ? 1 : 0;
        lg_cyc  = s_cyc;
        gp.push_back(lg_port);
        gc.push_back(s_cyc);
      end
    end
    check("rr_grants", gp.size(), 6);
    for (int i = 0; i < gp.size() && i < 6; i++) begin
      check($sformatf("rr_port%0d", i), gp[i], i % 2);
      if (i > 0) check($sformatf("rr_gap%0d", i), gc[i] - gc[i-1], 2);
    end
`endif

    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
